t05_htree_ctrl: RTL

Sequencer for the Huffman tree-build stage. Each iteration it starts the find-least-two unit, enables the tree-node builder (ht_en), serves the builder's null-sum SRAM reads, and writes the new tree node and any nulled leaf words back to SRAM through a single req/ack port. It loops until the find-least unit reports zero remaining sum, then signals done to the top-level FSM.

---
 rtl/t05_htree_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/t05_htree_ctrl.sv
// Huffman tree-build sequencer: drives find-least / node-builder iterations,
// serves the builder's null-sum reads and writes nodes back over one SRAM port.
module t05_htree_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] NODE_BASE = '0,
    parameter int                MAX_NODES = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              fl_start,
    input  logic              fl_done,
    input  logic              sum_zero,
    output logic              ht_en,
    input  logic [3:0]        ht_state,
    input  logic              ht_fin,
    input  logic [6:0]        null_idx,
    input  logic [70:0]       tree_node,
    input  logic [70:0]       null1,
    input  logic [70:0]       null2,
    output logic [63:0]       nulls,
    output logic              sram_finished,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [70:0]       sram_wdata,
    input  logic [63:0]       sram_rdata,
    input  logic              sram_ack,
    output logic [6:0]        node_count,
    output logic              done,
    output logic              error
);
    typedef enum logic [3:0] {
        IDLE, FIND, BUILD, WR_TREE, WR_N1, WR_N2, NEXT, DONE, ERR
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_NODES);

    state_t     state_reg;
    logic       null1_seen_reg;
    logic       null2_seen_reg;
    logic       rd_done_reg;
    logic [7:0] count_next;
    logic       rd_state;
    logic       ack_ok;

    // Count is widened so that reaching 128 with MAX_NODES=127 is still caught.
    assign count_next = {1'b0, node_count} + 8'd1;
    assign rd_state   = (ht_state == 4'd2) || (ht_state == 4'd4);
    assign ack_ok     = sram_req && sram_ack;

    function automatic logic [ADDR_W-1:0] node_addr(input logic [6:0] idx);
        return NODE_BASE + ADDR_W'(idx);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            null1_seen_reg <= 1'b0;
            null2_seen_reg <= 1'b0;
            rd_done_reg    <= 1'b0;
            fl_start       <= 1'b0;
            ht_en          <= 1'b0;
            nulls          <= '0;
            sram_finished  <= 1'b0;
            sram_req       <= 1'b0;
            sram_wr        <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            node_count     <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            fl_start      <= 1'b0;
            sram_finished <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fl_start       <= 1'b1;
                        node_count     <= '0;
                        null1_seen_reg <= 1'b0;
                        null2_seen_reg <= 1'b0;
                        state_reg      <= FIND;
                    end
                end
                FIND: begin
                    if (fl_done) begin
                        if (sum_zero) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ht_en       <= 1'b1;
                            rd_done_reg <= 1'b0;
                            state_reg   <= BUILD;
                        end
                    end
                end
                BUILD: begin
                    if (ht_state == 4'd3) null1_seen_reg <= 1'b1;
                    if (ht_state == 4'd5) null2_seen_reg <= 1'b1;
                    if (!rd_state) rd_done_reg <= 1'b0;
                    if (ack_ok) begin
                        sram_req      <= 1'b0;
                        nulls         <= sram_rdata;
                        sram_finished <= 1'b1;
                        rd_done_reg   <= 1'b1;
                    end else if (!sram_req && rd_state && !rd_done_reg) begin
                        sram_req  <= 1'b1;
                        sram_wr   <= 1'b0;
                        sram_addr <= node_addr(null_idx);
                    end
                    // The tree write is issued straight away so the next cycle already requests.
                    if (ht_fin && !sram_req) begin
                        ht_en      <= 1'b0;
                        sram_req   <= 1'b1;
                        sram_wr    <= 1'b1;
                        sram_addr  <= node_addr(tree_node[70:64]);
                        sram_wdata <= tree_node;
                        state_reg  <= WR_TREE;
                    end
                end
                WR_TREE: begin
                    if (ack_ok) begin
                        sram_req <= 1'b0;
                        if (null1_seen_reg)      state_reg <= WR_N1;
                        else if (null2_seen_reg) state_reg <= WR_N2;
                        else                     state_reg <= NEXT;
                    end
                end
                WR_N1: begin
                    if (!sram_req) begin
                        sram_req   <= 1'b1;
                        sram_wr    <= 1'b1;
                        sram_addr  <= node_addr(null1[70:64]);
                        sram_wdata <= null1;
                    end else if (sram_ack) begin
                        sram_req  <= 1'b0;
                        state_reg <= null2_seen_reg ? WR_N2 : NEXT;
                    end
                end
                WR_N2: begin
                    if (!sram_req) begin
                        sram_req   <= 1'b1;
                        sram_wr    <= 1'b1;
                        sram_addr  <= node_addr(null2[70:64]);
                        sram_wdata <= null2;
                    end else if (sram_ack) begin
                        sram_req  <= 1'b0;
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    node_count <= count_next[6:0];
                    if (count_next > MAX_CNT) begin
                        error     <= 1'b1;
                        state_reg <= ERR;
                    end else begin
                        fl_start       <= 1'b1;
                        null1_seen_reg <= 1'b0;
                        null2_seen_reg <= 1'b0;
                        state_reg      <= FIND;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ERR: begin
                    ht_en    <= 1'b0;
                    sram_req <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
